// File: rtl/tnn_wta_column.sv
// Ramp-no-leak TNN column: self-timed gamma cycle, 1-WTA inhibition, STDP.
// Optional runtime weight loading port set enabled by TNN_WEIGHT_LOAD_EN.
module tnn_wta_column #(
   parameter  int NUM_INPUTS  = 8,
   parameter  int NUM_NEURONS = 4,
   parameter  int WBITS       = 3,
   parameter  int TIME_PERIOD = 8,
   parameter  int THRESHOLD   = 12,
   parameter  int WINIT       = 4,
   localparam int TW          = $clog2(TIME_PERIOD) + 1,
   localparam int NW          = $clog2(NUM_NEURONS)
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     start,
   input  logic [NUM_INPUTS*TW-1:0] in_times,
   input  logic                     learn_en,
   output logic                     busy,
   output logic                     out_valid,
   output logic [TW-1:0]            out_time,
   output logic [NW-1:0]            winner
`ifdef TNN_WEIGHT_LOAD_EN
   ,input  logic                    wr_en
   ,input  logic [NW-1:0]           wr_neuron
   ,input  logic [$clog2(NUM_INPUTS)-1:0] wr_input
   ,input  logic [WBITS-1:0]        wr_data
`endif
);

   localparam int PW = WBITS + $clog2(NUM_INPUTS) + TW;
   localparam int LW = TW - 1;

   localparam logic [WBITS-1:0] WMAX   = '1;
   localparam logic [WBITS-1:0] WRST   = WBITS'(WINIT);
   localparam logic [PW-1:0]    THR    = PW'(THRESHOLD);
   localparam logic [TW-1:0]    TLAST  = TW'(TIME_PERIOD - 1);
   localparam logic [TW-1:0]    NOFIRE = TW'(TIME_PERIOD);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STDP,
      DONE
   } state_t;

   state_t state;

   logic [TW-1:0]    t;
   logic [TW-1:0]    times_q [NUM_INPUTS];
   logic             learn_q;
   logic [WBITS-1:0] w       [NUM_NEURONS][NUM_INPUTS];
   logic [PW-1:0]    pot     [NUM_NEURONS];
   logic             fired;
   logic [TW-1:0]    fire_t;
   logic [NW-1:0]    fire_n;

   logic [NUM_INPUTS-1:0]  active;
   logic [NUM_INPUTS-1:0]  spiked;
   logic [NUM_INPUTS-1:0]  early;
   logic [PW-1:0]          sum [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] hit;
   logic                   any_hit;
   logic [NW-1:0]          first_hit;

   function automatic logic [WBITS-1:0] sat_inc(input logic [WBITS-1:0] v);
      return (v == WMAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [WBITS-1:0] sat_dec(input logic [WBITS-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   // Ramp inputs: once a spike has arrived it stays active until cycle end.
   always_comb begin
      active = '0;
      spiked = '0;
      early  = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         spiked[i] = !times_q[i][TW-1];
         active[i] = spiked[i] && (times_q[i][LW-1:0] <= t[LW-1:0]);
         early[i]  = spiked[i] && (times_q[i] <= fire_t);
      end
   end

   always_comb begin
      hit = '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
         sum[n] = pot[n];
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (active[i]) begin
               sum[n] = sum[n] + PW'(w[n][i]);
            end
         end
         hit[n] = (sum[n] >= THR);
      end
   end

   always_comb begin
      any_hit   = |hit;
      first_hit = '0;
      for (int n = NUM_NEURONS - 1; n >= 0; n--) begin
         if (hit[n]) begin
            first_hit = NW'(n);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= IDLE;
         t         <= '0;
         learn_q   <= 1'b0;
         fired     <= 1'b0;
         fire_t    <= NOFIRE;
         fire_n    <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_time  <= NOFIRE;
         winner    <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            times_q[i] <= '1;
         end
         for (int n = 0; n < NUM_NEURONS; n++) begin
            pot[n] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  t       <= '0;
                  learn_q <= learn_en;
                  fired   <= 1'b0;
                  fire_t  <= NOFIRE;
                  fire_n  <= '0;
                  for (int i = 0; i < NUM_INPUTS; i++) begin
                     times_q[i] <= in_times[i*TW +: TW];
                  end
                  for (int n = 0; n < NUM_NEURONS; n++) begin
                     pot[n] <= '0;
                  end
               end
            end
            RUN: begin
               for (int n = 0; n < NUM_NEURONS; n++) begin
                  pot[n] <= sum[n];
               end
               // Only the earliest firing tick is kept: lateral inhibition.
               if (!fired && any_hit) begin
                  fired  <= 1'b1;
                  fire_t <= t;
                  fire_n <= first_hit;
               end
               if (t == TLAST) begin
                  state <= STDP;
               end else begin
                  t <= t + 1'b1;
               end
            end
            STDP: begin
               out_time  <= fired ? fire_t : NOFIRE;
               winner    <= fired ? fire_n : '0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               w[n][i] <= WRST;
            end
         end
      end else if (state == STDP && learn_q) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               if (fired) begin
                  if (NW'(n) == fire_n) begin
                     w[n][i] <= early[i] ? sat_inc(w[n][i]) : sat_dec(w[n][i]);
                  end
               end else if (spiked[i]) begin
                  w[n][i] <= sat_inc(w[n][i]);
               end
            end
         end
      end
`ifdef TNN_WEIGHT_LOAD_EN
      else if (state == IDLE && wr_en) begin
         w[wr_neuron][wr_input] <= wr_data;
      end
`endif
   end

endmodule

// File: tb/tb_tnn_wta_column.sv
// Bench for tnn_wta_column: random and directed volleys against a tick-level
// reference model of potentials, WTA and STDP.
module tb_tnn_wta_column;

   localparam int NI = 8;
   localparam int NN = 4;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   logic            start = 1'b0;
   logic            learn_en = 1'b0;
   logic [NI*TW-1:0] in_times = '1;
   logic            busy;
   logic            out_valid;
   logic [TW-1:0]   out_time;
   logic [1:0]      winner;
`ifdef TNN_WEIGHT_LOAD_EN
   logic            wr_en = 1'b0;
   logic [1:0]      wr_neuron = '0;
   logic [2:0]      wr_input = '0;
   logic [2:0]      wr_data = '0;
`endif

   int checks = 0;
   int failures = 0;
   int mw[NN][NI];

   always #5 clk = ~clk;

   tnn_wta_column dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .start     (start),
      .in_times  (in_times),
      .learn_en  (learn_en),
      .busy      (busy),
      .out_valid (out_valid),
      .out_time  (out_time),
      .winner    (winner)
`ifdef TNN_WEIGHT_LOAD_EN
      ,.wr_en     (wr_en)
      ,.wr_neuron (wr_neuron)
      ,.wr_input  (wr_input)
      ,.wr_data   (wr_data)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NI; i++)
            mw[n][i] = 4;
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst_l = 1'b0;
      tick();
      tick();
      rst_l = 1'b1;
      tick();
      model_reset();
   endtask

   // Reference: tm[i] < 0 means no spike. Updates mw when learning.
   task automatic model_volley(input int tm[NI], input bit learn,
                               output int et, output int ew);
      int p[NN];
      bit f;
      f = 0;
      et = 8;
      ew = 0;
      for (int n = 0; n < NN; n++) p[n] = 0;
      for (int tk = 0; tk < 8; tk++) begin
         for (int n = 0; n < NN; n++)
            for (int i = 0; i < NI; i++)
               if (tm[i] >= 0 && tm[i] <= tk) p[n] += mw[n][i];
         for (int n = 0; n < NN; n++)
            if (!f && p[n] >= 12) begin
               f = 1;
               et = tk;
               ew = n;
            end
      end
      if (learn) begin
         if (f) begin
            for (int i = 0; i < NI; i++)
               if (tm[i] >= 0 && tm[i] <= et)
                  mw[ew][i] = (mw[ew][i] < 7) ? mw[ew][i] + 1 : 7;
               else
                  mw[ew][i] = (mw[ew][i] > 0) ? mw[ew][i] - 1 : 0;
         end else begin
            for (int n = 0; n < NN; n++)
               for (int i = 0; i < NI; i++)
                  if (tm[i] >= 0)
                     mw[n][i] = (mw[n][i] < 7) ? mw[n][i] + 1 : 7;
         end
      end
   endtask

   function automatic logic [NI*TW-1:0] pack(input int tm[NI]);
      logic [NI*TW-1:0] v;
      v = '0;
      for (int i = 0; i < NI; i++)
         v[i*TW +: TW] = (tm[i] < 0) ? 4'b1000 : 4'(tm[i]);
      return v;
   endfunction

   task automatic weight_diff(output int bad);
      bad = 0;
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NI; i++)
            if (dut.w[n][i] !== 3'(mw[n][i])) bad++;
   endtask

   // lat = k where out_valid is seen in cycle c+k; bz = busy/out_valid samples.
   task automatic run_volley(input int tm[NI], input bit learn,
                             output int lat, output logic [3:0] ot,
                             output logic [1:0] wn, output logic [3:0] bz);
      in_times = pack(tm);
      learn_en = learn;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_times = $urandom;
      learn_en = 1'($urandom_range(0, 1));
      bz[3] = busy;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      ot = out_time;
      wn = winner;
      bz[2] = busy;
      tick();
      bz[1] = busy;
      bz[0] = out_valid;
   endtask

   task automatic test_reset();
      int bad;
      do_reset();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_time !== 4'd8) begin failures++; $display("FAIL reset_time got=%0d exp=8", out_time); end
      checks++;
      if (winner !== 2'd0) begin failures++; $display("FAIL reset_winner got=%0d exp=0", winner); end
      weight_diff(bad);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL reset_weights bad=%0d exp=0", bad); end
   endtask

   task automatic test_first_volley();
      int tm[NI];
      int et, ew, lat, bad;
      logic [3:0] ot, bz;
      logic [1:0] wn;
      do_reset();
      tm = '{0, 0, 0, -1, -1, -1, -1, -1};
      model_volley(tm, 1, et, ew);
      run_volley(tm, 1, lat, ot, wn, bz);
      checks++;
      if (lat != 10) begin failures++; $display("FAIL first_latency got=%0d exp=10", lat); end
      checks++;
      if (ot !== 4'd0 || ot !== 4'(et)) begin failures++; $display("FAIL first_time got=%0d exp=%0d", ot, et); end
      checks++;
      if (wn !== 2'd0 || wn !== 2'(ew)) begin failures++; $display("FAIL first_winner got=%0d exp=%0d", wn, ew); end
      checks++;
      if (bz !== 4'b1100) begin failures++; $display("FAIL first_handshake got=%b exp=1100", bz); end
      weight_diff(bad);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL first_weights bad=%0d exp=0", bad); end
      checks++;
      if (dut.w[0][1] !== 3'd5 || dut.w[0][5] !== 3'd3 || dut.w[3][1] !== 3'd4)
         begin failures++; $display("FAIL first_w_const got=%0d,%0d,%0d exp=5,3,4",
                                    dut.w[0][1], dut.w[0][5], dut.w[3][1]); end
   endtask

   task automatic test_single_late();
      int tm[NI];
      int et, ew, lat, bad;
      logic [3:0] ot, bz;
      logic [1:0] wn;
      do_reset();
      tm = '{-1, -1, -1, -1, -1, -1, 6, -1};
      model_volley(tm, 1, et, ew);
      run_volley(tm, 1, lat, ot, wn, bz);
      checks++;
      if (ot !== 4'd8 || ot !== 4'(et)) begin failures++; $display("FAIL late_time got=%0d exp=%0d", ot, et); end
      checks++;
      if (wn !== 2'(ew)) begin failures++; $display("FAIL late_winner got=%0d exp=%0d", wn, ew); end
      weight_diff(bad);
      checks++;
      if (bad != 0 || dut.w[2][6] !== 3'd5)
         begin failures++; $display("FAIL late_weights bad=%0d w26=%0d exp=0,5", bad, dut.w[2][6]); end
   endtask

   task automatic test_saturation();
      int tm[NI];
      int et, ew, lat, bad, errs;
      logic [3:0] ot, bz;
      logic [1:0] wn;
      do_reset();
      tm = '{0, 0, 0, -1, -1, -1, -1, -1};
      errs = 0;
      for (int r = 0; r < 5; r++) begin
         model_volley(tm, 1, et, ew);
         run_volley(tm, 1, lat, ot, wn, bz);
         if (ot !== 4'(et) || wn !== 2'(ew) || lat != 10) errs++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("FAIL sat_results bad_rounds=%0d exp=0", errs); end
      weight_diff(bad);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL sat_weights bad=%0d exp=0", bad); end
      checks++;
      if (dut.w[0][2] !== 3'd7 || dut.w[0][7] !== 3'd0)
         begin failures++; $display("FAIL sat_const got=%0d,%0d exp=7,0", dut.w[0][2], dut.w[0][7]); end
   endtask

   task automatic test_ignore_start();
      int tm[NI];
      int et, ew, k, bad, extra;
      do_reset();
      tm = '{2, 2, 2, 2, -1, -1, -1, -1};
      model_volley(tm, 1, et, ew);
      in_times = pack(tm);
      learn_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      in_times = '0;
      learn_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 4;
      while (out_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (k != 10) begin failures++; $display("FAIL ign_latency got=%0d exp=10", k); end
      checks++;
      if (out_time !== 4'(et) || winner !== 2'(ew))
         begin failures++; $display("FAIL ign_result got=%0d/%0d exp=%0d/%0d", out_time, winner, et, ew); end
      extra = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (busy !== 1'b0 || out_valid !== 1'b0) extra++;
      end
      checks++;
      if (extra != 0) begin failures++; $display("FAIL ign_rerun got=%0d exp=0", extra); end
      weight_diff(bad);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL ign_weights bad=%0d exp=0", bad); end
   endtask

`ifdef TNN_WEIGHT_LOAD_EN
   task automatic test_weight_load();
      int tm[NI];
      int et, ew, k, bad;
      do_reset();
      wr_en = 1'b1;
      wr_neuron = 2'd2;
      wr_input = 3'd0;
      wr_data = 3'd7;
      tick();
      mw[2][0] = 7;
      tm = '{0, 0, -1, -1, -1, -1, -1, -1};
      in_times = pack(tm);
      learn_en = 1'b0;
      wr_input = 3'd1;
      start = 1'b1;
      mw[2][1] = 7;
      model_volley(tm, 0, et, ew);
      tick();
      start = 1'b0;
      wr_neuron = 2'd0;
      wr_input = 3'd0;
      wr_data = 3'd0;
      k = 1;
      while (out_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      wr_en = 1'b0;
      checks++;
      if (k != 10) begin failures++; $display("FAIL load_latency got=%0d exp=10", k); end
      checks++;
      if (out_time !== 4'd0 || out_time !== 4'(et))
         begin failures++; $display("FAIL load_time got=%0d exp=%0d", out_time, et); end
      checks++;
      if (winner !== 2'd2 || winner !== 2'(ew))
         begin failures++; $display("FAIL load_winner got=%0d exp=%0d", winner, ew); end
      tick();
      weight_diff(bad);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL load_weights bad=%0d exp=0", bad); end
   endtask
`endif

   task automatic test_reset_mid_run();
      int tm[NI];
      int et, ew, lat, bad;
      logic [3:0] ot, bz;
      logic [1:0] wn;
      do_reset();
      tm = '{0, 0, 0, -1, -1, -1, -1, -1};
      model_volley(tm, 1, et, ew);
      run_volley(tm, 1, lat, ot, wn, bz);
      checks++;
      if (ot !== 4'(et)) begin failures++; $display("FAIL mid_pre_time got=%0d exp=%0d", ot, et); end
      tm = '{1, 0, 3, 2, -1, 5, -1, 0};
      in_times = pack(tm);
      learn_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst_l = 1'b0;
      #1;
      model_reset();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
         begin failures++; $display("FAIL mid_busy got=%b%b exp=00", busy, out_valid); end
      checks++;
      if (out_time !== 4'd8 || winner !== 2'd0)
         begin failures++; $display("FAIL mid_outputs got=%0d/%0d exp=8/0", out_time, winner); end
      weight_diff(bad);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL mid_weights bad=%0d exp=0", bad); end
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int tm[NI];
      int et, ew, lat, bad;
      logic [3:0] ot, bz;
      logic [1:0] wn;
      bit learn;
      do_reset();
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < NI; i++)
            tm[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7));
         learn = 1'($urandom_range(0, 1));
         model_volley(tm, learn, et, ew);
         run_volley(tm, learn, lat, ot, wn, bz);
         checks++;
         if (lat != 10 || bz !== 4'b1100)
            begin failures++; $display("FAIL rnd%0d_handshake lat=%0d bz=%b exp=10,1100", r, lat, bz); end
         checks++;
         if (ot !== 4'(et) || wn !== 2'(ew))
            begin failures++; $display("FAIL rnd%0d_result got=%0d/%0d exp=%0d/%0d", r, ot, wn, et, ew); end
         weight_diff(bad);
         checks++;
         if (bad != 0) begin failures++; $display("FAIL rnd%0d_weights bad=%0d exp=0", r, bad); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      test_reset();
      test_first_volley();
      test_single_late();
      test_saturation();
      test_ignore_start();
`ifdef TNN_WEIGHT_LOAD_EN
      test_weight_load();
`endif
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
